dcache_2way_wb: RTL and testbench

- Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU data port (p1_*) and the line-wide data memory (mem_*).
- Successor of the direct-mapped L1 data cache. Adds configurable line width and set count, a second way with per-set LRU replacement, and valid/dirty bits cleared at reset.
- Tag/data storage is internal register arrays. There are no external SRAM macros.

---
 rtl/dcache_2way_wb.sv | 145 ++++++++++++++
 tb/tb_dcache_2way_wb.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way_wb.sv
// 2-way set-associative, write-back, write-allocate L1 data cache with per-set LRU.
// Tags and lines live in internal register arrays; misses are serviced one line at a time.
module dcache_2way_wb #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       miss_cnt_o
);
  localparam int OFF_B  = $clog2(LINE_W / 8);
  localparam int WOFF_B = $clog2(WORD_W / 8);
  localparam int IDX_B  = $clog2(SETS);
  localparam int TAG_B  = ADDR_W - OFF_B - IDX_B;
  localparam int WSEL_B = OFF_B - WOFF_B;
  localparam int LBIT_B = $clog2(LINE_W);

  typedef enum logic [2:0] {IDLE, WRITEBACK, WB_GAP, FILL, FILL_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          valid_q [SETS];
  logic [1:0]          dirty_q [SETS];
  logic [SETS-1:0]     lru_q;
  logic [31:0]         miss_cnt_q;
  logic [TAG_B-1:0]    tag_q  [SETS][2];
  logic [LINE_W-1:0]   line_q [SETS][2];
  logic                vway_q;
  logic [IDX_B-1:0]    idx_q;
  logic [TAG_B-1:0]    rtag_q;

  logic [IDX_B-1:0]    idx;
  logic [TAG_B-1:0]    rtag;
  logic [WSEL_B-1:0]   wsel;
  logic [LBIT_B-1:0]   wbit;
  logic                req, store, hit, hit_way, victim, miss_start;
  logic [1:0]          match;
  logic [LINE_W-1:0]   hit_line;
  logic                unused_addr_bits;

  assign idx              = p1_addr_i[OFF_B+IDX_B-1:OFF_B];
  assign rtag             = p1_addr_i[ADDR_W-1:OFF_B+IDX_B];
  assign wsel             = p1_addr_i[OFF_B-1:WOFF_B];
  assign wbit             = {wsel, {$clog2(WORD_W){1'b0}}};
  assign unused_addr_bits = ^p1_addr_i[WOFF_B-1:0];
  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign store            = p1_MemWrite_i;

  always_comb begin
    match[0] = valid_q[idx][0] && (tag_q[idx][0] == rtag);
    match[1] = valid_q[idx][1] && (tag_q[idx][1] == rtag);
  end

  assign hit        = req && (state_q == IDLE) && (|match);
  assign hit_way    = match[1];
  assign hit_line   = line_q[idx][hit_way];
  assign miss_start = req && (state_q == IDLE) && !hit;
  // An invalid way is always refilled before any valid way is displaced.
  assign victim     = !valid_q[idx][0] ? 1'b0 :
                      !valid_q[idx][1] ? 1'b1 : lru_q[idx];

  assign p1_data_o  = hit ? hit_line[wbit +: WORD_W] : '0;
  assign p1_stall_o = req & ~hit;
  assign miss_cnt_o = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (miss_start)
          state_d = (valid_q[idx][victim] && dirty_q[idx][victim]) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx_q][vway_q], idx_q, {OFF_B{1'b0}}};
        mem_data_o   = line_q[idx_q][vway_q];
        if (mem_ack_i) state_d = WB_GAP;
      end
      WB_GAP: state_d = FILL;
      FILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {rtag_q, idx_q, {OFF_B{1'b0}}};
        if (mem_ack_i) state_d = FILL_DONE;
      end
      FILL_DONE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lru_q      <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (hit) begin
        lru_q[idx] <= ~hit_way;
        if (store) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == WRITEBACK && mem_ack_i) dirty_q[idx_q][vway_q] <= 1'b0;
      if (state_q == FILL && mem_ack_i) begin
        valid_q[idx_q][vway_q] <= 1'b1;
        dirty_q[idx_q][vway_q] <= 1'b0;
      end
    end
  end

  // Line/tag storage and the latched miss context carry no reset.
  always_ff @(posedge clk_i) begin
    if (hit && store) line_q[idx][hit_way][wbit +: WORD_W] <= p1_data_i;
    if (miss_start) begin
      vway_q <= victim;
      idx_q  <= idx;
      rtag_q <= rtag;
    end
    if (state_q == FILL && mem_ack_i) begin
      line_q[idx_q][vway_q] <= mem_data_i;
      tag_q[idx_q][vway_q]  <= rtag_q;
    end
  end
endmodule

// File: tb/tb_dcache_2way_wb.sv
// Randomized self-checking bench for dcache_2way_wb: a flat memory view of what the CPU
// should read, an LRU list per set predicting hits/evictions, and a line-wide memory responder.
module tb_dcache_2way_wb;
  logic         clk = 1'b0;
  logic         rst_i;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  p1_data_i, p1_addr_i;
  logic         p1_MemRead_i, p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  miss_cnt_o;

  dcache_2way_wb dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backing memory (line granularity) and the CPU-visible word view.
  logic [255:0] mem_line   [logic [31:0]];
  logic [31:0]  truth_word [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return ((a >> 5) - 32'd2) * 32'h0001_0100 + {29'd0, a[4:2]} + 32'd1;
  endfunction

  function automatic logic [255:0] line_rd(input logic [31:0] la);
    logic [255:0] l;
    if (mem_line.exists(la)) return mem_line[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [31:0] truth_rd(input logic [31:0] a);
    logic [255:0] l;
    if (truth_word.exists(a)) return truth_word[a];
    l = line_rd({a[31:5], 5'd0});
    return l[a[4:2]*32 +: 32];
  endfunction

  function automatic logic [255:0] truth_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = truth_rd(la + 32'(i * 4));
    return l;
  endfunction

  // Per set: resident tags in most-recent-first order.
  logic [22:0] m_tag   [16][2];
  bit          m_dirty [16][2];
  int          m_cnt   [16];
  int          model_miss;

  task automatic model_reset();
    for (int s = 0; s < 16; s++) m_cnt[s] = 0;
    model_miss = 0;
    truth_word.delete();
  endtask

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } tx_t;
  tx_t          txq[$];
  int           fixed_delay = 0;
  int           wait_cnt = 0;
  bit           busy = 1'b0;
  logic         pend_wr;
  logic [31:0]  pend_addr;
  logic [255:0] pend_data;

  always @(negedge clk) begin
    if (rst_i) begin
      mem_ack_i = 1'b0;
      busy = 1'b0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      busy = 1'b0;
      if (pend_wr) mem_line[pend_addr] = pend_data;
    end else if (mem_enable_o) begin
      if (!busy) begin
        busy = 1'b1;
        wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end
      if (wait_cnt == 0) begin
        mem_ack_i = 1'b1;
        pend_wr   = mem_write_o;
        pend_addr = mem_addr_o;
        pend_data = mem_data_o;
        txq.push_back('{mem_write_o, mem_addr_o, mem_data_o});
        if (!mem_write_o) mem_data_i = line_rd(mem_addr_o);
      end else begin
        wait_cnt--;
      end
    end
  end

  // Caller is 1 time unit after a rising edge; returns at the same phase one edge after the hit.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                        input int exp_cycles, input logic [15:0] exp_en);
    logic [3:0]   s;
    logic [22:0]  tg;
    logic [31:0]  wb_addr, exp_data;
    logic [255:0] wb_line;
    logic [15:0]  en_trace;
    bit           miss, wb, st;
    int           pos, cycles;
    tx_t          t;
    s = a[8:5]; tg = a[31:9]; st = wr;
    pos = -1; miss = 0; wb = 0; wb_addr = '0; wb_line = '0;
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == tg) pos = i;
    if (pos < 0) begin
      miss = 1;
      model_miss++;
      if (m_cnt[s] == 2 && m_dirty[s][1]) begin
        wb = 1;
        wb_addr = {m_tag[s][1], s, 5'd0};
        wb_line = truth_line(wb_addr);
      end
      m_tag[s][1] = m_tag[s][0]; m_dirty[s][1] = m_dirty[s][0];
      m_tag[s][0] = tg;          m_dirty[s][0] = 1'b0;
      if (m_cnt[s] < 2) m_cnt[s]++;
    end else if (pos == 1) begin
      m_tag[s][1] = m_tag[s][0]; m_tag[s][0] = tg;
      {m_dirty[s][0], m_dirty[s][1]} = {m_dirty[s][1], m_dirty[s][0]};
    end
    if (st) m_dirty[s][0] = 1'b1;
    exp_data = truth_rd(a);

    p1_addr_i = a; p1_data_i = wd; p1_MemWrite_i = wr; p1_MemRead_i = rd;
    #1;
    check_eq("first_stall", p1_stall_o, miss);
    if (miss) check_eq("miss_data_zero", p1_data_o, 32'd0);
    cycles = 0; en_trace = '0;
    while (p1_stall_o && cycles < 400) begin
      if (cycles < 16) en_trace[cycles] = mem_enable_o;
      @(posedge clk); #2;
      cycles++;
    end
    if (p1_stall_o) check_eq("stall_timeout", p1_stall_o, 1'b0);
    check_eq("rdata", p1_data_o, exp_data);
    check_eq("miss_cnt", miss_cnt_o, model_miss);
    if (exp_cycles >= 0) begin
      check_eq("latency", cycles, exp_cycles);
      check_eq("enable_trace", en_trace, exp_en);
    end
    if (wb) begin
      if (txq.size() == 0) check_eq("wb_missing", 1'b0, 1'b1);
      else begin
        t = txq.pop_front();
        check_eq("wb_write", t.wr, 1'b1);
        check_eq("wb_addr", t.addr, wb_addr);
        check_eq("wb_data", t.data, wb_line);
      end
    end
    if (miss) begin
      if (txq.size() == 0) check_eq("fill_missing", 1'b0, 1'b1);
      else begin
        t = txq.pop_front();
        check_eq("fill_write", t.wr, 1'b0);
        check_eq("fill_addr", t.addr, {a[31:5], 5'd0});
      end
    end
    check_eq("extra_mem_tx", txq.size(), 0);
    if (st) truth_word[a] = wd;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    #1;
    check_eq("idle_stall", p1_stall_o, 1'b0);
    check_eq("idle_data", p1_data_o, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    int op;
    rst_i = 1'b1; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    p1_addr_i = '0; p1_data_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    check_eq("rst_enable", mem_enable_o, 1'b0);
    check_eq("rst_write", mem_write_o, 1'b0);
    check_eq("rst_addr", mem_addr_o, 32'd0);
    check_eq("rst_wdata", mem_data_o, 256'd0);
    check_eq("rst_miss_cnt", miss_cnt_o, 32'd0);
    check_eq("rst_stall", p1_stall_o, 1'b0);
    @(posedge clk); #1;

    fixed_delay = 0;
    access(0, 1, 32'h040, 32'h0, 3, 16'h0002);
    access(1, 0, 32'h044, 32'hDEADBEEF, 0, 16'h0);
    access(0, 1, 32'h044, 32'h0, 0, 16'h0);
    access(0, 1, 32'h048, 32'h0, 0, 16'h0);
    access(0, 1, 32'h240, 32'h0, 3, 16'h0002);
    access(0, 1, 32'h040, 32'h0, 0, 16'h0);
    access(0, 1, 32'h240, 32'h0, 0, 16'h0);
    access(0, 1, 32'h440, 32'h0, 5, 16'h000A);
    access(0, 1, 32'h240, 32'h0, 0, 16'h0);
    fixed_delay = 10;
    access(0, 1, 32'h040, 32'h0, 13, 16'h0FFE);
    idle_cycle();

    fixed_delay = 100;
    p1_addr_i = 32'h640; p1_MemRead_i = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_eq("fill_pending", mem_enable_o, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    check_eq("async_rst_enable", mem_enable_o, 1'b0);
    check_eq("async_rst_write", mem_write_o, 1'b0);
    check_eq("async_rst_miss_cnt", miss_cnt_o, 32'd0);
    p1_MemRead_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
    txq.delete();
    fixed_delay = 0;
    @(posedge clk); #1;
    access(0, 1, 32'h240, 32'h0, 3, 16'h0002);

    fixed_delay = -1;
    for (int n = 0; n < 300; n++) begin
      a = ({30'd0, 2'($urandom_range(0, 3))} << 9) | ({28'd0, 4'($urandom_range(0, 15))} << 5)
          | ({29'd0, 3'($urandom_range(0, 7))} << 2);
      op = $urandom_range(0, 3);
      case (op)
        0, 1:    access(0, 1, a, $urandom, -1, 16'h0);
        2:       access(1, 0, a, $urandom, -1, 16'h0);
        default: access(1, 1, a, $urandom, -1, 16'h0);
      endcase
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
